// File: rtl/segasys1_pkg.sv
// segasys1_pkg: shared loader types and constants
package segasys1_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} loader_state_t;
  typedef struct packed {
    logic [24:0] addr;
    logic [7:0]  data;
  } loader_entry_t;
  localparam logic [24:0] DEFAULT_TILE_BASE = 25'h20000;
endpackage

// File: rtl/loader_fifo.sv
// loader_fifo: synchronous FIFO of download bytes with occupancy count
module loader_fifo
  import segasys1_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  loader_entry_t            din,
  input  logic                     pop,
  output loader_entry_t            dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int W = $clog2(DEPTH);
  loader_entry_t mem [DEPTH];
  logic [W-1:0] rd, wr;
  assign dout  = mem[rd];
  assign full  = count == (W+1)'(DEPTH);
  assign empty = count == '0;
  // storage array, written only when the caller has checked full
  always_ff @(posedge clk)
    if (push) mem[wr] <= din;
  // pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wr + W'(1);
      if (pop) rd <= rd + W'(1);
      count <= count + (W+1)'(push) - (W+1)'(pop);
    end
endmodule

// File: rtl/ioctl_sdram_loader.sv
// ioctl_sdram_loader: ioctl byte stream to sdram toggle-handshake writes (option LOADER_CHECKSUM_EN adds byte checksum)
module ioctl_sdram_loader
  import segasys1_pkg::*;
#(
  parameter logic [24:0] TILE_BASE  = DEFAULT_TILE_BASE,
  parameter int          FIFO_DEPTH = 4,
  parameter int          RESET_HOLD = 16
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_downl,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        status_reset,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic        port1_we,
  output logic [15:0] port1_d,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic [22:0] port2_a,
  output logic [1:0]  port2_ds,
  output logic        port2_we,
  output logic [15:0] port2_d,
  output logic        busy,
  output logic        overflow,
  output logic        rom_loaded,
  output logic        core_reset
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [15:0] checksum
`endif
);
  localparam int HW = $clog2(RESET_HOLD + 1);
  loader_state_t state, next;
  loader_entry_t in_q, fifo_out, hold;
  logic wr_q, wr_q2, dl_q, dl_q2, sel, pend, pop, full, empty, is_tile, done;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [23:0] off;
  logic [HW-1:0] cnt;
  wire push_ev = wr_q & ~wr_q2 & dl_q;
  wire push    = push_ev & ~full;
  wire dl_rise = dl_q & ~dl_q2;
  wire dl_fall = ~dl_q & dl_q2;
  assign is_tile    = hold.addr >= TILE_BASE;
  assign off        = hold.addr[23:0] - (is_tile ? TILE_BASE[23:0] : 24'd0);
  assign done       = sel ? port2_ack == port2_req : port1_ack == port1_req;
  assign busy       = fifo_count != '0 || state != IDLE;
  assign core_reset = status_reset | ~rom_loaded | (cnt != '0);
  loader_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk_sys), .rst_n(reset_n), .push(push), .din(in_q), .pop(pop),
    .dout(fifo_out), .full(full), .empty(empty), .count(fifo_count)
  );
  // sample strobe, download flag and byte so edges and payload stay aligned
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      {wr_q, wr_q2, dl_q, dl_q2} <= '0;
      in_q <= '0;
    end else begin
      {wr_q, wr_q2, dl_q, dl_q2} <= {ioctl_wr, wr_q, ioctl_downl, dl_q};
      in_q <= {ioctl_addr, ioctl_dout};
    end
  // FSM state register
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= next;
  // next state and FIFO pop
  always_comb begin
    next = state;
    pop  = 1'b0;
    unique case (state)
      IDLE:  if (!empty) begin pop = 1'b1; next = ISSUE; end
      ISSUE: next = WAIT;
      WAIT:  if (done) next = IDLE;
      default: next = IDLE;
    endcase
  end
  // holding register and port drive; the unused port keeps its last values
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      hold <= '0;
      sel  <= 1'b0;
      {port1_req, port1_a, port1_ds, port1_we, port1_d} <= '0;
      {port2_req, port2_a, port2_ds, port2_we, port2_d} <= '0;
    end else begin
      if (pop) hold <= fifo_out;
      if (state == ISSUE) begin
        sel <= is_tile;
        if (is_tile) {port2_req, port2_a, port2_ds, port2_we, port2_d} <= {~port2_req, off[23:1], off[0], ~off[0], 1'b1, hold.data, hold.data};
        else {port1_req, port1_a, port1_ds, port1_we, port1_d} <= {~port1_req, off[23:1], off[0], ~off[0], 1'b1, hold.data, hold.data};
      end
    end
  // overflow, load completion and core reset hold counter
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      overflow   <= 1'b0;
      pend       <= 1'b0;
      rom_loaded <= 1'b0;
      cnt        <= HW'(RESET_HOLD);
    end else begin
      if (dl_rise) begin
        overflow   <= 1'b0;
        pend       <= 1'b0;
        rom_loaded <= 1'b0;
      end else begin
        if (dl_fall) pend <= 1'b1;
        if (pend && empty && state == IDLE) rom_loaded <= 1'b1;
      end
      if (push_ev && full) overflow <= 1'b1;
      cnt <= (status_reset || !rom_loaded) ? HW'(RESET_HOLD) : (cnt != '0 ? cnt - HW'(1) : cnt);
    end
`ifdef LOADER_CHECKSUM_EN
  // running sum of accepted bytes, frozen once the image is loaded
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) checksum <= '0;
    else if (dl_rise) checksum <= '0;
    else if (push && !rom_loaded) checksum <= checksum + 16'(in_q.data);
`endif
endmodule

// File: tb/tb_ioctl_sdram_loader.sv
// tb_ioctl_sdram_loader: scoreboard bench for the ioctl to sdram loader
module tb_ioctl_sdram_loader;
  localparam logic [24:0] TB = 25'h20000;
  localparam int HOLD = 16;
  typedef struct packed {
    logic        port;
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } exp_t;
  logic clk, reset_n, ioctl_downl, ioctl_wr, status_reset, port1_ack, port2_ack;
  logic [24:0] ioctl_addr;
  logic [7:0] ioctl_dout;
  logic port1_req, port1_we, port2_req, port2_we, busy, overflow, rom_loaded, core_reset;
  logic [22:0] port1_a, port2_a;
  logic [1:0] port1_ds, port2_ds;
  logic [15:0] port1_d, port2_d;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif
  int tests = 0, fails = 0;
  bit hold_ack = 0;
  exp_t expq[$];
  exp_t last_e[2];

  ioctl_sdram_loader dut (
    .clk_sys(clk), .reset_n(reset_n), .ioctl_downl(ioctl_downl), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .status_reset(status_reset),
    .port1_req(port1_req), .port1_ack(port1_ack), .port1_a(port1_a), .port1_ds(port1_ds),
    .port1_we(port1_we), .port1_d(port1_d),
    .port2_req(port2_req), .port2_ack(port2_ack), .port2_a(port2_a), .port2_ds(port2_ds),
    .port2_we(port2_we), .port2_d(port2_d),
    .busy(busy), .overflow(overflow), .rom_loaded(rom_loaded), .core_reset(core_reset)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [24:0] addr, input logic [7:0] b);
    exp_t e;
    logic [24:0] off;
    e.port = addr >= TB;
    off = e.port ? addr - TB : addr;
    e.a = off[23:1];
    e.ds = {off[0], ~off[0]};
    e.d = {b, b};
    return e;
  endfunction

  task automatic chk_reset_vals(input string name);
    chk(name, {port1_req, port2_req, port1_a, port2_a, port1_ds, port2_ds, port1_d, port2_d,
               port1_we, port2_we, busy, overflow, rom_loaded, core_reset}, 64'd1);
  endtask

  task automatic send(input logic [24:0] a, input logic [7:0] b, input bit exp_it, input int hi, input int lo);
    @(negedge clk);
    ioctl_addr = a;
    ioctl_dout = b;
    ioctl_wr = 1;
    if (exp_it) expq.push_back(model(a, b));
    repeat (hi) @(negedge clk);
    ioctl_wr = 0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((expq.size() != 0 || busy) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 64'(n < 1000), 64'd1);
  endtask

  // sdram model: echo each request toggle after a random short delay
  initial begin
    int d1 = 0, d2 = 0;
    port1_ack = 0;
    port2_ack = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        port1_ack = 0;
        port2_ack = 0;
      end else begin
        if (port1_req != port1_ack && !hold_ack) begin
          if (d1 == 0) port1_ack = port1_req; else d1--;
        end else d1 = $urandom_range(0, 2);
        if (port2_req != port2_ack && !hold_ack) begin
          if (d2 == 0) port2_ack = port2_req; else d2--;
        end else d2 = $urandom_range(0, 2);
      end
    end
  end

  // monitor: every request toggle pops one expected write
  initial begin
    logic p1 = 0, p2 = 0, t1, t2;
    exp_t e, act;
    last_e[0] = '0;
    last_e[1] = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        p1 = 0;
        p2 = 0;
        last_e[0] = '0;
        last_e[1] = '0;
        expq.delete();
      end else begin
        t1 = port1_req != p1;
        t2 = port2_req != p2;
        if (t1 || t2) begin
          chk("both_ports_toggled", 64'(t1 & t2), 64'd0);
          if (expq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_req: port1_req %0b port2_req %0b with no byte expected", port1_req, port2_req);
          end else begin
            e = expq.pop_front();
            act = t2 ? {1'b1, port2_a, port2_ds, port2_d} : {1'b0, port1_a, port1_ds, port1_d};
            chk("req_payload", 64'(act), 64'(e));
            chk("req_we", 64'(t2 ? port2_we : port1_we), 64'd1);
            if (t2) chk("idle_port1_kept", {port1_a, port1_ds, port1_d}, 64'(last_e[0][40:0]));
            else chk("idle_port2_kept", {port2_a, port2_ds, port2_d}, 64'(last_e[1][40:0]));
            last_e[t2] = act;
          end
          p1 = port1_req;
          p2 = port2_req;
        end
        if (port1_req != port1_ack) chk("port1_stable", {port1_a, port1_ds, port1_d}, 64'(last_e[0][40:0]));
        if (port2_req != port2_ack) chk("port2_stable", {port2_a, port2_ds, port2_d}, 64'(last_e[1][40:0]));
      end
    end
  end

  initial begin
    int n;
    reset_n = 0; ioctl_downl = 0; ioctl_wr = 0; ioctl_addr = 0; ioctl_dout = 0; status_reset = 0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset_vals");
    reset_n = 1;
    // directed bytes from the plan
    @(negedge clk);
    ioctl_downl = 1;
    repeat (3) @(negedge clk);
    send(25'h00005, 8'hA5, 1, 2, 2);
    wait_idle();
    chk("p1_byte5", {port1_a, port1_ds, port1_d, port2_req}, {23'h2, 2'b10, 16'hA5A5, 1'b0});
    send(25'h20001, 8'h3C, 1, 2, 2);
    wait_idle();
    chk("p2_byte", {port2_a, port2_ds, port2_d, port2_req}, {23'h0, 2'b10, 16'h3C3C, 1'b1});
    chk("p1_untouched", {port1_a, port1_req}, {23'h2, 1'b1});
    // randomized bytes, both regions and stray bit 24
    for (int i = 0; i < 40; i++)
      send($urandom_range(0, 1) ? 25'($urandom_range(0, 32'h1FFFF)) : 25'($urandom), 8'($urandom), 1, 2, 4);
    wait_idle();
    chk("loaded_during_dl", 64'(rom_loaded), 64'd0);
    // download ends with bytes still queued
    hold_ack = 1;
    for (int i = 0; i < 3; i++) send(25'(i * 2 + 100), 8'($urandom), 1, 2, 2);
    ioctl_downl = 0;
    repeat (10) @(negedge clk);
    chk("loaded_early", {rom_loaded, busy}, 64'b01);
    hold_ack = 0;
    n = 0;
    while (!rom_loaded && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("loaded_timeout", 64'(n < 200), 64'd1);
    chk("loaded_after_acks", {expq.size() == 0, port1_req == port1_ack, port2_req == port2_ack}, 64'b111);
    n = 0;
    while (core_reset && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("core_reset_hold", 64'(n), 64'(HOLD));
    // one-cycle OSD reset
    @(negedge clk);
    status_reset = 1;
    #1 chk("status_reset_on", 64'(core_reset), 64'd1);
    @(negedge clk);
    status_reset = 0;
    #1 n = 1;
    while (core_reset && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk("status_reset_len", 64'(n), 64'(HOLD + 1));
    // overflow with ack held off
    @(negedge clk);
    ioctl_downl = 1;
    repeat (3) @(negedge clk);
    chk("new_dl_flags", {overflow, rom_loaded}, 64'b00);
    hold_ack = 1;
    for (int i = 0; i < 6; i++) send(25'(i + 16), 8'($urandom), i < 5, 2, 2);
    repeat (6) @(negedge clk);
    chk("overflow_set", 64'(overflow), 64'd1);
    hold_ack = 0;
    wait_idle();
    chk("overflow_sticky", 64'(overflow), 64'd1);
    ioctl_downl = 0;
    repeat (HOLD + 10) @(negedge clk);
    // strobes outside a download are ignored
    send(25'h40, 8'h11, 0, 2, 2);
    send(25'h20040, 8'h22, 0, 2, 2);
    repeat (8) @(negedge clk);
    chk("ignored_busy", 64'(busy), 64'd0);
    // asynchronous reset in WAIT
    ioctl_downl = 1;
    repeat (3) @(negedge clk);
    hold_ack = 1;
    send(25'h20010, 8'h77, 1, 2, 2);
    n = 0;
    while (port1_req == port1_ack && port2_req == port2_ack && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wait_toggle", 64'(n < 50), 64'd1);
    #2 reset_n = 0;
    #1 chk_reset_vals("async_reset_vals");
    hold_ack = 0;
    ioctl_downl = 0;
    repeat (3) @(negedge clk);
    reset_n = 1;
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
